// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the TotalALU. It issues single-cycle ops, sequences
// MULTU with its MFHI/MFLO read-back, and queues results in a 2-entry FIFO.
module alu_cmd_sequencer #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic        alu_reset,
  input  logic [31:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_SLL   = 6'd0;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_MUL_LOAD,
    S_MUL_RUN,
    S_MFHI,
    S_MFLO,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         sig_q, sig_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        fifo_data_q [2];
  logic [31:0]        fifo_data_d [2];
  logic               fifo_err_q [2];
  logic               fifo_err_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;

  logic               accept;
  logic               push;
  logic [31:0]        push_data;
  logic               push_err;
  logic               pop;

  function automatic logic is_single_op(input logic [5:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL};
  endfunction

  // Only accept with an empty FIFO, so the two MULTU pushes can never stall.
  assign cmd_ready  = !reset && (state_q == S_IDLE) && (count_q == 2'd0);
  assign alu_reset  = reset || (state_q == S_MUL_LOAD);
  assign alu_signal = sig_q;
  assign alu_dataA  = a_q;
  assign alu_dataB  = b_q;
  assign res_valid  = (count_q != 2'd0);
  assign res_data   = fifo_data_q[rd_ptr_q];
  assign res_err    = fifo_err_q[rd_ptr_q];
  assign accept     = cmd_valid && cmd_ready;
  assign pop        = res_valid && res_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    a_d       = a_q;
    b_d       = b_q;
    push      = 1'b0;
    push_data = '0;
    push_err  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_MULTU || is_single_op(cmd_op)) begin
            sig_d   = cmd_op;
            a_d     = cmd_a;
            b_d     = cmd_b;
            state_d = (cmd_op == OP_MULTU) ? S_MUL_LOAD : S_ISSUE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ISSUE: begin
        push      = 1'b1;
        push_data = alu_out;
        state_d   = S_IDLE;
      end
      S_MUL_LOAD: begin
        sig_d   = OP_MULTU;
        cnt_d   = CNT_W'(MUL_CYCLES - 1);
        state_d = S_MUL_RUN;
      end
      S_MUL_RUN: begin
        if (cnt_q == '0) begin
          sig_d   = OP_MFHI;
          state_d = S_MFHI;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_MFHI: begin
        push      = 1'b1;
        push_data = alu_out;
        sig_d     = OP_MFLO;
        state_d   = S_MFLO;
      end
      S_MFLO: begin
        push      = 1'b1;
        push_data = alu_out;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        push     = 1'b1;
        push_err = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = push_data;
      fifo_err_d[wr_ptr_q]  = push_err;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sig_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fifo_data_q <= '{default: '0};
      fifo_err_q  <= '{default: 1'b0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fifo_data_q <= fifo_data_d;
      fifo_err_q  <= fifo_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule
